// File: rtl/wavelet_core_pkg.sv
// Shared register map, CONFIG/STATUS bit positions and bus-slave FSM states
// for the wavelet core bus interface.
package wavelet_core_pkg;

  localparam logic [1:0] REG_CONFIG   = 2'd0;
  localparam logic [1:0] REG_DATA_IN  = 2'd1;
  localparam logic [1:0] REG_DATA_OUT = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam int CFG_FS_LSB   = 0;
  localparam int CFG_DS_BIT   = 5;
  localparam int CFG_DL_LSB   = 6;
  localparam int CFG_IL_LSB   = 8;
  localparam int CFG_GO_BIT   = 10;
  localparam int CFG_INIT_BIT = 11;

  localparam int STAT_GO_BIT     = 0;
  localparam int STAT_INIT_BIT   = 1;
  localparam int STAT_AVAIL_BIT  = 2;
  localparam int STAT_UFLOW_BIT  = 3;
  localparam int STAT_CFGERR_BIT = 4;
  localparam int STAT_DL_LSB     = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_PULSE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_RET   = 2'd3
  } bus_if_state_t;

endpackage

// File: rtl/wavelet_core_bus_if.sv
// CPU-bus slave in front of the wavelet core: config register, DATA_IN strobe,
// DATA_OUT service read through the obuff, and the sticky STATUS bits.
module wavelet_core_bus_if
  import wavelet_core_pkg::*;
#(
  parameter int  INPUT_WIDTH     = 32,
  parameter int  MAX_FILTER_SIZE = 32,
  parameter int  ADDR_WIDTH      = 2,
  localparam int FS_WIDTH        = $clog2(MAX_FILTER_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  bus_address,
  input  logic                   bus_write,
  input  logic [INPUT_WIDTH-1:0] bus_writedata,
  input  logic                   bus_read,
  output logic [INPUT_WIDTH-1:0] bus_readdata,
  output logic                   bus_readdatavalid,
  output logic                   bus_waitrequest,
  output logic [INPUT_WIDTH-1:0] core_data_in,
  output logic                   core_input_reg_en_pulse,
  output logic                   core_output_reg_en_pulse,
  input  logic [INPUT_WIDTH-1:0] core_data_out,
  input  logic                   obuff_r_data_available,
  output logic [FS_WIDTH-1:0]    core_filter_size,
  output logic                   core_downsample,
  output logic [1:0]             core_dec_level,
  output logic [1:0]             core_inputs_len,
  output logic                   core_go,
  output logic                   core_init,
  input  logic                   clear_core_go,
  input  logic                   clear_core_init,
  input  logic [1:0]             cur_dec_level
);

  bus_if_state_t          r_state;
  logic                   r_wait;
  logic [INPUT_WIDTH-1:0] r_rdata;
  logic                   r_rvalid;
  logic                   r_in_pulse;
  logic                   r_out_pulse;
  logic [INPUT_WIDTH-1:0] r_data_in;
  logic [FS_WIDTH-1:0]    r_filter_size;
  logic                   r_downsample;
  logic [1:0]             r_dec_level;
  logic [1:0]             r_inputs_len;
  logic                   r_go;
  logic                   r_init;
  logic                   r_uflow;
  logic                   r_cfg_err;

  logic [1:0]             w_reg;
  logic                   w_idle;
  logic                   w_wr;
  logic                   w_rd;
  logic [INPUT_WIDTH-1:0] w_cfg_word;
  logic [INPUT_WIDTH-1:0] w_stat_word;

  assign w_reg  = bus_address[1:0];
  assign w_idle = (r_state == IDLE);
  assign w_wr   = w_idle & bus_write;
  // A simultaneous write takes the slot; the read is retried by the master.
  assign w_rd   = w_idle & bus_read & ~bus_write;

  always_comb begin
    w_cfg_word                            = '0;
    w_cfg_word[CFG_FS_LSB +: FS_WIDTH]    = r_filter_size;
    w_cfg_word[CFG_DS_BIT]                = r_downsample;
    w_cfg_word[CFG_DL_LSB +: 2]           = r_dec_level;
    w_cfg_word[CFG_IL_LSB +: 2]           = r_inputs_len;
    w_cfg_word[CFG_GO_BIT]                = r_go;
    w_cfg_word[CFG_INIT_BIT]              = r_init;
  end

  always_comb begin
    w_stat_word                    = '0;
    w_stat_word[STAT_GO_BIT]       = r_go;
    w_stat_word[STAT_INIT_BIT]     = r_init;
    w_stat_word[STAT_AVAIL_BIT]    = obuff_r_data_available;
    w_stat_word[STAT_UFLOW_BIT]    = r_uflow;
    w_stat_word[STAT_CFGERR_BIT]   = r_cfg_err;
    w_stat_word[STAT_DL_LSB +: 2]  = cur_dec_level;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_wait        <= 1'b0;
      r_rdata       <= '0;
      r_rvalid      <= 1'b0;
      r_in_pulse    <= 1'b0;
      r_out_pulse   <= 1'b0;
      r_data_in     <= '0;
      r_filter_size <= '0;
      r_downsample  <= 1'b0;
      r_dec_level   <= '0;
      r_inputs_len  <= '0;
      r_go          <= 1'b0;
      r_init        <= 1'b0;
      r_uflow       <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_in_pulse  <= 1'b0;
      r_out_pulse <= 1'b0;
      r_rvalid    <= 1'b0;
      r_go        <= r_go & ~clear_core_go;
      r_init      <= r_init & ~clear_core_init;

      unique case (r_state)
        IDLE: begin
          if (w_wr) begin
            if (w_reg == REG_CONFIG) begin
              // Fields are frozen for the whole job once go or init is up.
              if (r_go | r_init) begin
                r_cfg_err <= 1'b1;
              end else begin
                r_filter_size <= bus_writedata[CFG_FS_LSB +: FS_WIDTH];
                r_downsample  <= bus_writedata[CFG_DS_BIT];
                r_dec_level   <= bus_writedata[CFG_DL_LSB +: 2];
                r_inputs_len  <= bus_writedata[CFG_IL_LSB +: 2];
                r_go          <= bus_writedata[CFG_GO_BIT] & ~clear_core_go;
                r_init        <= bus_writedata[CFG_INIT_BIT] & ~clear_core_init;
              end
            end else if (w_reg == REG_DATA_IN) begin
              r_data_in  <= bus_writedata;
              r_in_pulse <= 1'b1;
            end
          end else if (w_rd) begin
            unique case (w_reg)
              REG_CONFIG: begin
                r_rdata  <= w_cfg_word;
                r_rvalid <= 1'b1;
              end
              REG_DATA_IN: begin
                r_rdata  <= '0;
                r_rvalid <= 1'b1;
              end
              REG_DATA_OUT: begin
                if (obuff_r_data_available) begin
                  r_out_pulse <= 1'b1;
                  r_state     <= RD_PULSE;
                  r_wait      <= 1'b1;
                end else begin
                  r_rdata  <= '0;
                  r_rvalid <= 1'b1;
                  r_uflow  <= 1'b1;
                end
              end
              default: begin
                r_rdata   <= w_stat_word;
                r_rvalid  <= 1'b1;
                r_uflow   <= 1'b0;
                r_cfg_err <= 1'b0;
              end
            endcase
          end
        end
        // obuff sees the pulse this cycle and presents its word next cycle
        RD_PULSE: begin
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          r_rdata  <= core_data_out;
          r_rvalid <= 1'b1;
          r_state  <= RD_RET;
        end
        // RD_RET: return strobe is on the bus this cycle
        default: begin
          r_state <= IDLE;
          r_wait  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_readdata             = r_rdata;
  assign bus_readdatavalid        = r_rvalid;
  assign bus_waitrequest          = r_wait;
  assign core_data_in             = r_data_in;
  assign core_input_reg_en_pulse  = r_in_pulse;
  assign core_output_reg_en_pulse = r_out_pulse;
  assign core_filter_size         = r_filter_size;
  assign core_downsample          = r_downsample;
  assign core_dec_level           = r_dec_level;
  assign core_inputs_len          = r_inputs_len;
  assign core_go                  = r_go;
  assign core_init                = r_init;

endmodule

// File: tb/tb_wavelet_core_bus_if.sv
// Bench for wavelet_core_bus_if: directed scenarios then random bus traffic
// checked against a register-level model of the slave.
module tb_wavelet_core_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  bus_address;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic        bus_read;
  logic [31:0] bus_readdata;
  logic        bus_readdatavalid;
  logic        bus_waitrequest;
  logic [31:0] core_data_in;
  logic        core_input_reg_en_pulse;
  logic        core_output_reg_en_pulse;
  logic [31:0] core_data_out;
  logic        obuff_r_data_available;
  logic [4:0]  core_filter_size;
  logic        core_downsample;
  logic [1:0]  core_dec_level;
  logic [1:0]  core_inputs_len;
  logic        core_go;
  logic        core_init;
  logic        clear_core_go;
  logic        clear_core_init;
  logic [1:0]  cur_dec_level;

  wavelet_core_bus_if dut (
    .clk                      (clk),
    .rst                      (rst),
    .bus_address              (bus_address),
    .bus_write                (bus_write),
    .bus_writedata            (bus_writedata),
    .bus_read                 (bus_read),
    .bus_readdata             (bus_readdata),
    .bus_readdatavalid        (bus_readdatavalid),
    .bus_waitrequest          (bus_waitrequest),
    .core_data_in             (core_data_in),
    .core_input_reg_en_pulse  (core_input_reg_en_pulse),
    .core_output_reg_en_pulse (core_output_reg_en_pulse),
    .core_data_out            (core_data_out),
    .obuff_r_data_available   (obuff_r_data_available),
    .core_filter_size         (core_filter_size),
    .core_downsample          (core_downsample),
    .core_dec_level           (core_dec_level),
    .core_inputs_len          (core_inputs_len),
    .core_go                  (core_go),
    .core_init                (core_init),
    .clear_core_go            (clear_core_go),
    .clear_core_init          (clear_core_init),
    .cur_dec_level            (cur_dec_level)
  );

  always #5 clk = ~clk;

  // obuff: registered read, word valid only in the cycle after the request
  logic [31:0] obuf_word;
  always @(posedge clk) begin
    if (core_output_reg_en_pulse) core_data_out <= obuf_word;
    else                          core_data_out <= $urandom();
  end

  int n_checks = 0;
  int n_errors = 0;

  // model of the programmer-visible state
  logic [11:0] m_cfg;
  logic [31:0] m_din;
  logic        m_uf;
  logic        m_err;

  logic [11:0] w_cfg_obs;
  assign w_cfg_obs = {core_init, core_go, core_inputs_len, core_dec_level,
                      core_downsample, core_filter_size};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus_waitrequest !== 1'b0 && n < 10) begin
      cyc();
      n++;
    end
    if (n >= 10) check_eq("wait_idle_timeout", {31'd0, bus_waitrequest}, 32'd0);
  endtask

  function automatic logic [31:0] exp_status();
    return {25'd0, cur_dec_level, m_err, m_uf, obuff_r_data_available, m_cfg[11], m_cfg[10]};
  endfunction

  task automatic model_reset();
    m_cfg = '0;
    m_din = '0;
    m_uf  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] data,
                          input bit cg, input bit ci);
    wait_idle();
    bus_address     = addr;
    bus_writedata   = data;
    bus_write       = 1'b1;
    clear_core_go   = cg;
    clear_core_init = ci;
    cyc();
    bus_write       = 1'b0;
    clear_core_go   = 1'b0;
    clear_core_init = 1'b0;
    if (addr == 2'd0) begin
      if (m_cfg[10] | m_cfg[11]) m_err = 1'b1;
      else                       m_cfg = data[11:0];
    end else if (addr == 2'd1) begin
      m_din = data;
    end
    if (cg) m_cfg[10] = 1'b0;
    if (ci) m_cfg[11] = 1'b0;
    check_eq("wr_in_pulse", {31'd0, core_input_reg_en_pulse}, {31'd0, addr == 2'd1});
    check_eq("wr_data_in", core_data_in, m_din);
    check_eq("wr_cfg", {20'd0, w_cfg_obs}, {20'd0, m_cfg});
    check_eq("wr_no_rvalid", {31'd0, bus_readdatavalid}, 32'd0);
  endtask

  task automatic idle_clear(input bit cg, input bit ci);
    wait_idle();
    clear_core_go   = cg;
    clear_core_init = ci;
    cyc();
    clear_core_go   = 1'b0;
    clear_core_init = 1'b0;
    if (cg) m_cfg[10] = 1'b0;
    if (ci) m_cfg[11] = 1'b0;
    check_eq("clr_cfg", {20'd0, w_cfg_obs}, {20'd0, m_cfg});
  endtask

  task automatic do_read(input logic [1:0] addr, input bit avail,
                         input logic [31:0] word, output logic [31:0] rd);
    logic [31:0] exp;
    int          lat;
    bit          long_rd;
    wait_idle();
    obuff_r_data_available = avail;
    obuf_word              = word;
    lat     = 1;
    long_rd = 1'b0;
    case (addr)
      2'd0: exp = {20'd0, m_cfg};
      2'd1: exp = 32'd0;
      2'd2: begin
        if (avail) begin
          exp     = word;
          lat     = 3;
          long_rd = 1'b1;
        end else begin
          exp = 32'd0;
        end
      end
      default: exp = exp_status();
    endcase
    bus_address = addr;
    bus_read    = 1'b1;
    cyc();
    bus_read = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      if (i > 1) cyc();
      check_eq("rd_valid", {31'd0, bus_readdatavalid}, {31'd0, i == lat});
      check_eq("rd_out_pulse", {31'd0, core_output_reg_en_pulse}, {31'd0, long_rd && i == 1});
      check_eq("rd_waitreq", {31'd0, bus_waitrequest}, {31'd0, long_rd});
      if (i == 1) check_eq("rd_in_pulse", {31'd0, core_input_reg_en_pulse}, 32'd0);
      if (i == lat) check_eq("rd_data", bus_readdata, exp);
    end
    rd = bus_readdata;
    if (addr == 2'd3) begin
      m_uf  = 1'b0;
      m_err = 1'b0;
    end else if (addr == 2'd2 && !avail) begin
      m_uf = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rvalid"}, {31'd0, bus_readdatavalid}, 32'd0);
    check_eq({tag, "_wait"}, {31'd0, bus_waitrequest}, 32'd0);
    check_eq({tag, "_pulses"}, {30'd0, core_input_reg_en_pulse, core_output_reg_en_pulse}, 32'd0);
    check_eq({tag, "_rdata"}, bus_readdata, 32'd0);
    check_eq({tag, "_data_in"}, core_data_in, 32'd0);
    check_eq({tag, "_cfg"}, {20'd0, w_cfg_obs}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    rst = 1'b0;
    bus_address = '0; bus_write = 1'b0; bus_writedata = '0; bus_read = 1'b0;
    obuff_r_data_available = 1'b0; obuf_word = '0;
    clear_core_go = 1'b0; clear_core_init = 1'b0; cur_dec_level = '0;
    model_reset();
    repeat (3) cyc();
    check_all_zero("reset");
    rst = 1'b1;
    cyc();

    // CONFIG with go+init, dropped rewrite, cfg_err via STATUS
    do_write(2'd0, 32'h0000_0C5F, 1'b0, 1'b0);
    check_eq("fs31", {27'd0, core_filter_size}, 32'd31);
    check_eq("ds0", {31'd0, core_downsample}, 32'd0);
    check_eq("dl1", {30'd0, core_dec_level}, 32'd1);
    check_eq("il0", {30'd0, core_inputs_len}, 32'd0);
    check_eq("go_init", {30'd0, core_init, core_go}, 32'd3);
    do_write(2'd0, 32'h0000_0123, 1'b0, 1'b0);
    do_read(2'd3, 1'b0, 32'd0, rd);
    check_eq("status13", rd, 32'h13);
    do_read(2'd3, 1'b0, 32'd0, rd);
    check_eq("status_err_clr", rd, 32'h03);

    // back-to-back DATA_IN
    do_write(2'd1, 32'hA5A5_0001, 1'b0, 1'b0);
    do_write(2'd1, 32'h0000_0002, 1'b0, 1'b0);
    cyc();
    check_eq("in_pulse_end", {31'd0, core_input_reg_en_pulse}, 32'd0);

    // DATA_OUT service read and underflow
    do_read(2'd2, 1'b1, 32'h1234_5678, rd);
    check_eq("dout", rd, 32'h1234_5678);
    do_read(2'd2, 1'b0, 32'hDEAD_BEEF, rd);
    do_read(2'd3, 1'b0, 32'd0, rd);
    check_eq("uflow_set", {31'd0, rd[3]}, 32'd1);
    do_read(2'd3, 1'b0, 32'd0, rd);
    check_eq("uflow_clr", {31'd0, rd[3]}, 32'd0);
    do_read(2'd1, 1'b0, 32'd0, rd);

    // clear wins over set
    idle_clear(1'b1, 1'b1);
    do_write(2'd0, 32'h0000_0400, 1'b1, 1'b0);
    check_eq("clr_wins", {31'd0, core_go}, 32'd0);

    // simultaneous read + write: write first, read served next
    wait_idle();
    bus_address = 2'd0; bus_writedata = 32'h0000_00A5;
    bus_write = 1'b1; bus_read = 1'b1;
    cyc();
    bus_write = 1'b0;
    m_cfg = 12'h0A5;
    check_eq("rw_no_rvalid", {31'd0, bus_readdatavalid}, 32'd0);
    check_eq("rw_cfg", {20'd0, w_cfg_obs}, 32'h0A5);
    cyc();
    bus_read = 1'b0;
    check_eq("rw_rvalid", {31'd0, bus_readdatavalid}, 32'd1);
    check_eq("rw_rdata", bus_readdata, 32'h0A5);

    // reset in RD_WAIT of a DATA_OUT read
    do_write(2'd1, 32'h5555_AAAA, 1'b0, 1'b0);
    wait_idle();
    obuff_r_data_available = 1'b1; obuf_word = 32'hCAFE_F00D;
    bus_address = 2'd2; bus_read = 1'b1;
    cyc();
    bus_read = 1'b0;
    cyc();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all_zero("midrst");
    cyc();
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("post_rst_rvalid", {31'd0, bus_readdatavalid}, 32'd0);
      check_eq("post_rst_pulse", {31'd0, core_output_reg_en_pulse}, 32'd0);
    end

    // random traffic
    for (int k = 0; k < 300; k++) begin
      int op;
      op = int'($urandom_range(0, 7));
      cur_dec_level = 2'($urandom_range(0, 3));
      case (op)
        0, 1: do_write(2'd0, $urandom(), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        2:    do_write(2'd1, $urandom(), 1'b0, 1'b0);
        3:    do_write(2'($urandom_range(2, 3)), $urandom(), 1'b0, 1'b0);
        4:    idle_clear(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: do_read(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom(), rd);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
